// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv_pipe_pkg
//  Description : Shared types and constants for the RV32I pipeline control.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Stage indices into the per-stage bubble/flush vectors
    localparam int F = 0;
    localparam int D = 1;
    localparam int E = 2;
    localparam int M = 3;
    localparam int W = 4;

    localparam int N_STAGES   = 5;
    localparam int WAIT_CNT_W = 8;

endpackage : rv_pipe_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Compares ID source registers against the EX load destination.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import rv_pipe_pkg::*;
(
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       rs1_used_ID,
    input  logic       rs2_used_ID,
    input  logic [4:0] rd_EX,
    input  logic       mem_read_EX,
    output logic       load_use
);

    logic w_rd_valid;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_rd_valid = (rd_EX != REG_X0);
    assign w_rs1_hit  = rs1_used_ID && (rs1_ID == rd_EX);
    assign w_rs2_hit  = rs2_used_ID && (rs2_ID == rd_EX);
    assign load_use   = mem_read_EX && w_rd_valid && (w_rs1_hit || w_rs2_hit);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush sequencer with data-memory timeout guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_EX,
    input  logic             mem_read_EX,
    input  logic             br_taken_EX,
    input  logic             jal_ID,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [WAIT_CNT_W-1:0] C_WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    hz_state_t               r_state;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]        r_stall_cnt;

    logic                    w_load_use;
    logic                    w_mem_stall;
    logic [N_STAGES-1:0]     w_bubble;
    logic [N_STAGES-1:0]     w_flush;

    load_use_detect u_load_use_detect (
        .rs1_ID      (rs1_ID),
        .rs2_ID      (rs2_ID),
        .rs1_used_ID (rs1_used_ID),
        .rs2_used_ID (rs2_used_ID),
        .rd_EX       (rd_EX),
        .mem_read_EX (mem_read_EX),
        .load_use    (w_load_use)
    );

    assign w_mem_stall = dmem_req_MEM && !dmem_ready;

    // The wait count includes the RUN cycle that first saw the unready request,
    // so the fault lands exactly MEM_TIMEOUT cycles after that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!dmem_req_MEM || dmem_ready) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == C_WAIT_LAST) begin
                        r_state <= FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                FAULT: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        w_bubble = '0;
        w_flush  = '0;
        if (r_state == FAULT) begin
            w_bubble[F] = 1'b1;
            w_flush[D]  = 1'b1;
            w_flush[E]  = 1'b1;
            w_flush[M]  = 1'b1;
            w_flush[W]  = 1'b1;
        end else if (w_mem_stall) begin
            w_bubble[F] = 1'b1;
            w_bubble[D] = 1'b1;
            w_bubble[E] = 1'b1;
            w_bubble[M] = 1'b1;
            w_flush[W]  = 1'b1;
        end else if (br_taken_EX) begin
            // Fetch keeps running so the PC picks up the redirect target
            w_flush[D] = 1'b1;
            w_flush[E] = 1'b1;
        end else if (w_load_use) begin
            w_bubble[F] = 1'b1;
            w_bubble[D] = 1'b1;
            w_flush[E]  = 1'b1;
        end else if (jal_ID) begin
            w_flush[D] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_bubble[F] && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bubbleF      = w_bubble[F];
    assign bubbleD      = w_bubble[D];
    assign bubbleE      = w_bubble[E];
    assign bubbleM      = w_bubble[M];
    assign bubbleW      = w_bubble[W];
    assign flushF       = w_flush[F];
    assign flushD       = w_flush[D];
    assign flushE       = w_flush[E];
    assign flushM       = w_flush[M];
    assign flushW       = w_flush[W];
    assign mem_fault    = (r_state == FAULT);
    assign stall_cycles = r_stall_cnt;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_CNT_W   = 4;

    // {bubbleF,D,E,M,W, flushF,D,E,M,W}
    localparam logic [9:0] C_NONE  = 10'b00000_00000;
    localparam logic [9:0] C_LU    = 10'b11000_00100;
    localparam logic [9:0] C_MEM   = 10'b11110_00001;
    localparam logic [9:0] C_REDIR = 10'b00000_01100;
    localparam logic [9:0] C_FAULT = 10'b10000_01111;
    localparam logic [9:0] C_JAL   = 10'b00000_01000;

    logic                clk;
    logic                rst_n;
    logic [4:0]          rs1_ID, rs2_ID, rd_EX;
    logic                rs1_used_ID, rs2_used_ID, mem_read_EX;
    logic                br_taken_EX, jal_ID, dmem_req_MEM, dmem_ready;
    logic                bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic                flushF, flushD, flushE, flushM, flushW;
    logic                mem_fault;
    logic [TB_CNT_W-1:0] stall_cycles;
    logic [9:0]          ctl;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .rs1_used_ID  (rs1_used_ID),
        .rs2_used_ID  (rs2_used_ID),
        .rd_EX        (rd_EX),
        .mem_read_EX  (mem_read_EX),
        .br_taken_EX  (br_taken_EX),
        .jal_ID       (jal_ID),
        .dmem_req_MEM (dmem_req_MEM),
        .dmem_ready   (dmem_ready),
        .bubbleF      (bubbleF),
        .bubbleD      (bubbleD),
        .bubbleE      (bubbleE),
        .bubbleM      (bubbleM),
        .bubbleW      (bubbleW),
        .flushF       (flushF),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .flushW       (flushW),
        .mem_fault    (mem_fault),
        .stall_cycles (stall_cycles)
    );

    assign ctl = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                  flushF, flushD, flushE, flushM, flushW};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
        rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; mem_read_EX = 1'b0;
        br_taken_EX = 1'b0; jal_ID = 1'b0;
        dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu();
        mem_read_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; rs1_used_ID = 1'b1;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ctl", 32'(ctl), 32'(C_NONE));
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_fault", 32'(mem_fault), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load-use on rs1, then on rs2, then non-hazards
        set_lu(); #1;
        check("lu_rs1", 32'(ctl), 32'(C_LU));
        tick(); clr_in(); #1;
        check("lu_release", 32'(ctl), 32'(C_NONE));
        check("lu_count", 32'(stall_cycles), 32'd1);
        mem_read_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7; rs2_used_ID = 1'b1; rs1_ID = 5'd3; rs1_used_ID = 1'b1; #1;
        check("lu_rs2", 32'(ctl), 32'(C_LU));
        tick(); clr_in();
        mem_read_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; rs1_used_ID = 1'b1; #1;
        check("lu_x0", 32'(ctl), 32'(C_NONE));
        mem_read_EX = 1'b1; rd_EX = 5'd9; rs1_ID = 5'd9; rs1_used_ID = 1'b0; #1;
        check("lu_unused_src", 32'(ctl), 32'(C_NONE));
        tick(); clr_in(); #1;
        check("lu_count2", 32'(stall_cycles), 32'd2);

        // Redirect beats load-use, load-use beats jal
        do_reset();
        set_lu(); br_taken_EX = 1'b1; #1;
        check("redir_over_lu", 32'(ctl), 32'(C_REDIR));
        tick(); clr_in(); #1;
        check("redir_no_count", 32'(stall_cycles), 32'd0);
        jal_ID = 1'b1; #1;
        check("jal_only", 32'(ctl), 32'(C_JAL));
        set_lu(); #1;
        check("lu_over_jal", 32'(ctl), 32'(C_LU));
        tick(); clr_in(); #1;
        check("jal_lu_count", 32'(stall_cycles), 32'd1);

        // Memory wait of three cycles
        do_reset();
        dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("memwait_ctl", 32'(ctl), 32'(C_MEM));
            check("memwait_nofault", 32'(mem_fault), 32'd0);
            tick();
        end
        dmem_ready = 1'b1; #1;
        check("memwait_done", 32'(ctl), 32'(C_NONE));
        tick(); clr_in(); #1;
        check("memwait_count", 32'(stall_cycles), 32'd3);
        check("memwait_run", 32'(mem_fault), 32'd0);
        jal_ID = 1'b1; #1;
        check("memwait_back_run", 32'(ctl), 32'(C_JAL));
        clr_in();

        // Timeout: fault pulse in cycle 5
        do_reset();
        dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("to_wait_ctl", 32'(ctl), 32'(C_MEM));
            check("to_wait_fault", 32'(mem_fault), 32'd0);
            tick();
        end
        #1;
        check("to_fault_ctl", 32'(ctl), 32'(C_FAULT));
        check("to_fault_pulse", 32'(mem_fault), 32'd1);
        tick(); clr_in(); #1;
        check("to_after_fault", 32'(mem_fault), 32'd0);
        check("to_after_ctl", 32'(ctl), 32'(C_NONE));
        check("to_count", 32'(stall_cycles), 32'd5);

        // Ready in the timeout cycle wins
        do_reset();
        dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick();
        dmem_ready = 1'b1; #1;
        check("to_ready_ctl", 32'(ctl), 32'(C_NONE));
        tick(); clr_in(); #1;
        check("to_ready_nofault", 32'(mem_fault), 32'd0);
        check("to_ready_count", 32'(stall_cycles), 32'd3);

        // Reset asserted while in WAIT
        do_reset();
        dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b0; #1;
        check("rstwait_count", 32'(stall_cycles), 32'd0);
        check("rstwait_fault", 32'(mem_fault), 32'd0);
        check("rstwait_ctl", 32'(ctl), 32'(C_MEM));
        clr_in();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rstwait_nopulse", 32'(mem_fault), 32'd0);
            tick();
        end
        // A fresh request must take the full timeout again
        dmem_req_MEM = 1'b1;
        tick(); tick(); tick(); #1;
        check("rstwait_restart", 32'(mem_fault), 32'd0);
        tick(); #1;
        check("rstwait_refault", 32'(mem_fault), 32'd1);
        clr_in();

        // Counter saturation at 4 bits
        do_reset();
        set_lu();
        for (int i = 0; i < 20; i++) tick();
        clr_in(); #1;
        check("sat_count", 32'(stall_cycles), 32'd15);
        tick(); #1;
        check("sat_hold", 32'(stall_cycles), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
